branch_resolver: RTL and testbench

Registered, parametrised branch-resolution unit for the pipelined processor, the successor to the purely combinational condition checker. It does three things:
- Evaluates an extended set of branch conditions on two register operands.
- Registers the taken decision and branch target.
- Sequences a multi-cycle pipeline flush, with stall support and a saturating taken-branch counter.

It sits at the end of the decode/register-read stage and feeds the PC mux and the pipeline-register flush controls.

---
 rtl/branch_pkg.sv | 22 ++
 rtl/br_cond_eval.sv | 29 ++
 rtl/branch_resolver.sv | 107 ++++++++++
 tb/tb_branch_resolver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch command encoding and resolver state types.
package branch_pkg;

    localparam int CMD_W = 3;

    typedef logic [CMD_W-1:0] br_cmd_t;

    localparam br_cmd_t CMD_NONE = 3'd0;
    localparam br_cmd_t CMD_BEZ  = 3'd1;
    localparam br_cmd_t CMD_BNE  = 3'd2;
    localparam br_cmd_t CMD_JMP  = 3'd3;
    localparam br_cmd_t CMD_BEQ  = 3'd4;
    localparam br_cmd_t CMD_BLT  = 3'd5;
    localparam br_cmd_t CMD_BGE  = 3'd6;
    localparam br_cmd_t CMD_BLTU = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } br_state_t;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluation over full-width operands.
module br_cond_eval
    import branch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    input  br_cmd_t          br_cmd,
    output logic             cond
);

    // Decode the command into a taken/not-taken condition.
    always_comb begin
        cond = 1'b0;
        case (br_cmd)
            CMD_NONE: cond = 1'b0;
            CMD_BEZ:  cond = (reg1 == '0);
            CMD_BNE:  cond = (reg1 != reg2);
            CMD_JMP:  cond = 1'b1;
            CMD_BEQ:  cond = (reg1 == reg2);
            CMD_BLT:  cond = ($signed(reg1) <  $signed(reg2));
            CMD_BGE:  cond = ($signed(reg1) >= $signed(reg2));
            CMD_BLTU: cond = (reg1 < reg2);
            default:  cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Registered branch resolution: taken pulse, target register, multi-cycle
// flush sequencing with stall, and a saturating taken-branch counter.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int PC_WIDTH     = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic                 stall,
    input  logic [CMD_W-1:0]     br_cmd,
    input  logic [WIDTH-1:0]     reg1,
    input  logic [WIDTH-1:0]     reg2,
    input  logic [PC_WIDTH-1:0]  target_pc,
    output logic                 br_taken,
    output logic [PC_WIDTH-1:0]  br_target,
    output logic                 flush,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] taken_count
);

    // Flush counter only ever holds FLUSH_CYCLES-1 down to 0.
    localparam int            FCW     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FC_LOAD = FCW'(FLUSH_CYCLES - 1);
    // A single-cycle flush never needs the FLUSH state.
    localparam bit            MULTI   = (FLUSH_CYCLES > 1);

    br_state_t      state, state_nxt;
    logic [FCW-1:0] fcnt;
    logic           cond;
    logic           accept;
    logic           fcnt_done;
    logic           load_cnt;
    logic           dec_cnt;
    logic           flush_nxt;

    br_cond_eval #(.WIDTH(WIDTH)) u_cond (
        .reg1   (reg1),
        .reg2   (reg2),
        .br_cmd (br_cmd_t'(br_cmd)),
        .cond   (cond)
    );

    // A branch is taken only when idle with flush already low, so the
    // earliest re-acceptance is the first cycle flush reads 0.
    assign accept    = (state == ST_IDLE) && valid_in && !stall && cond && !flush;
    assign fcnt_done = (fcnt == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: enter FLUSH on a taken branch, leave when the counter
    // expires on an unstalled cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept && MULTI)       state_nxt = ST_FLUSH;
            ST_FLUSH: if (!stall && fcnt_done)   state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes for the datapath registers.
    always_comb begin
        load_cnt  = accept;
        dec_cnt   = 1'b0;
        flush_nxt = 1'b0;
        case (state)
            ST_IDLE:  flush_nxt = accept;
            ST_FLUSH: begin
                dec_cnt   = !stall && !fcnt_done;
                flush_nxt = stall || !fcnt_done;
            end
            default:  flush_nxt = 1'b0;
        endcase
    end

    // Output, target, flush counter and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken    <= 1'b0;
            br_target   <= '0;
            flush       <= 1'b0;
            fcnt        <= '0;
            taken_count <= '0;
        end else begin
            br_taken <= accept;
            flush    <= flush_nxt;
            if (accept) begin
                br_target <= target_pc;
                if (taken_count != '1) taken_count <= taken_count + 1'b1;
            end
            if (load_cnt)     fcnt <= FC_LOAD;
            else if (dec_cnt) fcnt <= fcnt - 1'b1;
        end
    end

    assign busy = (state == ST_FLUSH);

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized bench for branch_resolver: three configurations share one
// stimulus stream and are compared each cycle against a cycle-count model.
module tb_branch_resolver;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  br_cmd = '0;
    logic [31:0] reg1 = '0;
    logic [31:0] reg2 = '0;
    logic [31:0] target_pc = '0;

    logic        tk0, tk1, tk2;
    logic [31:0] tg0, tg1, tg2;
    logic        fl0, fl1, fl2;
    logic        bs0, bs1, bs2;
    logic [15:0] cn0;
    logic [1:0]  cn1;
    logic [15:0] cn2;

    always #5 clk = ~clk;

    branch_resolver #(.WIDTH(32), .PC_WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .br_cmd(br_cmd),
        .reg1(reg1), .reg2(reg2), .target_pc(target_pc), .br_taken(tk0),
        .br_target(tg0), .flush(fl0), .busy(bs0), .taken_count(cn0));

    branch_resolver #(.WIDTH(32), .PC_WIDTH(32), .FLUSH_CYCLES(1), .CNT_WIDTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .br_cmd(br_cmd),
        .reg1(reg1), .reg2(reg2), .target_pc(target_pc), .br_taken(tk1),
        .br_target(tg1), .flush(fl1), .busy(bs1), .taken_count(cn1));

    branch_resolver #(.WIDTH(32), .PC_WIDTH(32), .FLUSH_CYCLES(3), .CNT_WIDTH(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall), .br_cmd(br_cmd),
        .reg1(reg1), .reg2(reg2), .target_pc(target_pc), .br_taken(tk2),
        .br_target(tg2), .flush(fl2), .busy(bs2), .taken_count(cn2));

    // Model: per configuration, remaining flush-high cycles and totals.
    int          fc   [NDUT] = '{2, 1, 3};
    int          cmax [NDUT] = '{65535, 3, 65535};
    int          rem  [NDUT];
    int          cnt  [NDUT];
    logic [31:0] tgt  [NDUT];
    bit          mtk  [NDUT];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_of(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd1:    return a == 0;
            3'd2:    return a != b;
            3'd3:    return 1'b1;
            3'd4:    return a == b;
            3'd5:    return $signed(a) <  $signed(b);
            3'd6:    return $signed(a) >= $signed(b);
            3'd7:    return a < b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            rem[d] = 0; cnt[d] = 0; tgt[d] = '0; mtk[d] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < NDUT; d++) begin
            if (rem[d] == 0) begin
                mtk[d] = valid_in && !stall && cond_of(br_cmd, reg1, reg2);
                if (mtk[d]) begin
                    tgt[d] = target_pc;
                    if (cnt[d] < cmax[d]) cnt[d]++;
                    rem[d] = fc[d];
                end
            end else begin
                mtk[d] = 1'b0;
                // A one-cycle flush drops regardless of stall.
                if (!stall || fc[d] == 1) rem[d]--;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".tk0"}, 64'(tk0), 64'(mtk[0]));
        chk({tag, ".tg0"}, 64'(tg0), 64'(tgt[0]));
        chk({tag, ".fl0"}, 64'(fl0), 64'(rem[0] > 0));
        chk({tag, ".bs0"}, 64'(bs0), 64'(rem[0] > 0));
        chk({tag, ".cn0"}, 64'(cn0), 64'(cnt[0]));
        chk({tag, ".tk1"}, 64'(tk1), 64'(mtk[1]));
        chk({tag, ".tg1"}, 64'(tg1), 64'(tgt[1]));
        chk({tag, ".fl1"}, 64'(fl1), 64'(rem[1] > 0));
        chk({tag, ".bs1"}, 64'(bs1), 64'(0));
        chk({tag, ".cn1"}, 64'(cn1), 64'(cnt[1]));
        chk({tag, ".tk2"}, 64'(tk2), 64'(mtk[2]));
        chk({tag, ".tg2"}, 64'(tg2), 64'(tgt[2]));
        chk({tag, ".fl2"}, 64'(fl2), 64'(rem[2] > 0));
        chk({tag, ".bs2"}, 64'(bs2), 64'(rem[2] > 0));
        chk({tag, ".cn2"}, 64'(cn2), 64'(cnt[2]));
    endtask

    task automatic drive(input bit v, input bit s, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] t);
        valid_in = v; stall = s; br_cmd = c; reg1 = a; reg2 = b; target_pc = t;
    endtask

    // One clock: model advances on the edge, outputs checked 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 3'd0, '0, '0, '0);
        for (int i = 0; i < n; i++) cycle("idle");
    endtask

    int fh;

    initial begin
        model_reset();
        #2;
        check_all("reset");
        #10 rst_n = 1'b1;

        // BEZ taken with reg1 = 0
        drive(1, 0, 3'd1, 32'd0, 32'd13, 32'h0000_1000);
        cycle("bez");
        chk("bez_taken", 64'(tk0), 64'd1);
        chk("bez_target", 64'(tg0), 64'h1000);
        idle(4);

        // BNE with equal operands, then unequal
        drive(1, 0, 3'd2, 32'd13, 32'd13, 32'h0000_2000);
        cycle("bne_eq");
        idle(1);
        drive(1, 0, 3'd2, 32'd1, 32'd13, 32'h0000_2004);
        cycle("bne_ne");
        idle(4);

        // Signed vs unsigned compares
        drive(1, 0, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'h0000_3000);
        cycle("blt");
        idle(4);
        drive(1, 0, 3'd7, 32'hFFFF_FFFF, 32'd1, 32'h0000_3004);
        cycle("bltu");
        idle(4);
        drive(1, 0, 3'd6, 32'd77, 32'd77, 32'h0000_3008);
        cycle("bge");
        idle(4);

        // JMP, then three stalled cycles with a JMP presented during flush
        drive(1, 0, 3'd3, '0, '0, 32'h0000_4000);
        cycle("jmp");
        fh = int'(fl0);
        drive(1, 1, 3'd3, '0, '0, 32'h0000_4444);
        for (int i = 0; i < 3; i++) begin
            cycle("jmp_stall");
            fh += int'(fl0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 3'd3, '0, '0, 32'h0000_4444);
            if (fl0) begin
                cycle("jmp_flush");
                fh += int'(fl0);
            end
        end
        chk("stall_flush_len", 64'(fh), 64'd5);
        idle(4);

        // Stall on the acceptance cycle blocks it; re-evaluated when stall drops
        drive(1, 1, 3'd4, 32'd5, 32'd5, 32'h0000_5000);
        cycle("acc_stall");
        drive(1, 0, 3'd4, 32'd5, 32'd6, 32'h0000_5004);
        cycle("acc_reeval");
        idle(4);

        // Back-to-back JMPs; the one-cycle config takes every second cycle
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 3'd3, '0, '0, 32'h0000_6000 + 32'(i));
            cycle("b2b");
        end
        chk("cnt_sat", 64'(cn1), 64'd3);
        idle(1);

        // Asynchronous reset between edges, mid-flush
        drive(1, 0, 3'd3, '0, '0, 32'h0000_7000);
        cycle("pre_rst");
        drive(0, 0, 3'd0, '0, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1 rst_n = 1'b1;
        drive(1, 0, 3'd3, '0, '0, 32'h0000_7100);
        cycle("post_rst");
        chk("post_rst_cnt", 64'(cn0), 64'd1);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: a = '0;
                default: ;
            endcase
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)), a, b, $urandom);
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
